// File: rtl/mac_accumulator_4bit.sv
// Multiply-accumulate stage: registers 4-bit operand pairs, multiplies them with
// multiplier_4bit and sums the products, flushing on a last term or MAX_TERMS terms.

module multiplier_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0000, a} * {4'b0000, b};

endmodule

module mac_accumulator_4bit #(
  parameter  int ACC_W     = 12,
  parameter  int MAX_TERMS = 16,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [3:0]       op_a_r;
  logic [3:0]       op_b_r;
  logic             op_last_r;
  logic [7:0]       prod_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [7:0]       prod_s;
  logic [ACC_W:0]   sum_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             flush_s;

  multiplier_4bit u_mult (
    .a (op_a_r),
    .b (op_b_r),
    .p (prod_s)
  );

  // Accumulate arithmetic; the extra top bit of sum_s is the wrap carry.
  always_comb begin
    sum_s     = {1'b0, acc_r} + {{(ACC_W-7){1'b0}}, prod_r};
    cnt_inc_s = cnt_r + CNT_ONE;
    flush_s   = op_last_r | (cnt_inc_s == MAX_CNT);
  end

  // Handshake state machine with all datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      op_a_r      <= 4'd0;
      op_b_r      <= 4'd0;
      op_last_r   <= 1'b0;
      prod_r      <= 8'd0;
      acc_r       <= {ACC_W{1'b0}};
      ovf_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (clr) begin
      state_r     <= S_IDLE;
      acc_r       <= {ACC_W{1'b0}};
      ovf_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            op_a_r     <= in_a;
            op_b_r     <= in_b;
            op_last_r  <= in_last;
            state_r    <= S_MUL;
            in_ready_r <= 1'b0;
          end else begin
            state_r    <= S_IDLE;
            in_ready_r <= 1'b1;
          end
        end
        S_MUL: begin
          prod_r  <= prod_s;
          state_r <= S_ACC;
        end
        S_ACC: begin
          acc_r <= sum_s[ACC_W-1:0];
          ovf_r <= ovf_r | sum_s[ACC_W];
          cnt_r <= cnt_inc_s;
          if (flush_s) begin
            state_r     <= S_OUT;
            out_valid_r <= 1'b1;
          end else begin
            state_r    <= S_IDLE;
            in_ready_r <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            acc_r       <= {ACC_W{1'b0}};
            ovf_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= S_OUT;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_acc      = acc_r;
  assign out_overflow = ovf_r;
  assign out_count    = cnt_r;

endmodule

// File: tb/tb_mac_accumulator_4bit.sv
// Directed bench for mac_accumulator_4bit: a default instance (ACC_W=12) and an
// ACC_W=8 instance share stimulus; expected values are hand-computed.

module tb_mac_accumulator_4bit;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_acc;
  logic        out_overflow;
  logic [4:0]  out_count;

  logic        in_ready8;
  logic        out_valid8;
  logic [7:0]  out_acc8;
  logic        out_overflow8;
  logic [4:0]  out_count8;

  int n_checks = 0;
  int n_pass   = 0;

  mac_accumulator_4bit u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_acc      (out_acc),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  mac_accumulator_4bit #(.ACC_W(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready8),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_last      (in_last),
    .out_valid    (out_valid8),
    .out_ready    (out_ready),
    .out_acc      (out_acc8),
    .out_overflow (out_overflow8),
    .out_count    (out_count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair, wait (bounded) for in_ready, and return 1ns after the accept edge.
  task automatic send_term(input logic [3:0] a, input logic [3:0] b, input logic last);
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    check("in_ready_wait", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_a = 4'd0; in_b = 4'd0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_acc", out_acc, 0);
    check("rst_count", out_count, 0);
    check("rst_ovf", out_overflow, 0);
    rst_n = 1'b1;
    step();

    // T1 single term
    send_term(4'd15, 4'd15, 1'b1);
    check("t1_valid_mul", out_valid, 0);
    check("t1_ready_mul", in_ready, 0);
    step();
    check("t1_valid_acc", out_valid, 0);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_acc", out_acc, 225);
    check("t1_ovf", out_overflow, 0);
    check("t1_count", out_count, 1);
    check("t1_in_ready", in_ready, 0);
    step();
    check("t1_valid_after", out_valid, 0);
    check("t1_acc_after", out_acc, 0);

    // T2 four terms, last on the fourth
    send_term(4'd3, 4'd5, 1'b0); step(); step();
    check("t2_acc1", out_acc, 15);
    check("t2_valid1", out_valid, 0);
    send_term(4'd2, 4'd7, 1'b0); step(); step();
    check("t2_acc2", out_acc, 29);
    check("t2_valid2", out_valid, 0);
    send_term(4'd15, 4'd1, 1'b0); step(); step();
    check("t2_acc3", out_acc, 44);
    check("t2_valid3", out_valid, 0);
    send_term(4'd0, 4'd9, 1'b1); step(); step();
    check("t2_valid", out_valid, 1);
    check("t2_acc", out_acc, 44);
    check("t2_count", out_count, 4);
    step();

    // T3 overflow on the 8-bit instance
    send_term(4'd15, 4'd15, 1'b0); step(); step();
    send_term(4'd15, 4'd15, 1'b1); step(); step();
    check("t3_valid8", out_valid8, 1);
    check("t3_acc8", out_acc8, 194);
    check("t3_ovf8", out_overflow8, 1);
    check("t3_acc12", out_acc, 450);
    check("t3_ovf12", out_overflow, 0);
    step();
    send_term(4'd1, 4'd1, 1'b1); step(); step();
    check("t3_next_acc8", out_acc8, 1);
    check("t3_next_ovf8", out_overflow8, 0);
    check("t3_next_count8", out_count8, 1);
    step();

    // T4 backpressure
    out_ready = 1'b0;
    send_term(4'd4, 4'd4, 1'b1); step(); step();
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_acc", out_acc, 16);
      check("t4_hold_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_valid_after", out_valid, 0);
    check("t4_ready_after", in_ready, 1);
    check("t4_acc_after", out_acc, 0);
    out_ready = 1'b1;

    // T5 forced flush after 16 terms
    for (int i = 1; i <= 16; i++) begin
      send_term(4'd1, 4'd1, 1'b0); step(); step();
      if (i == 15) begin
        check("t5_valid15", out_valid, 0);
        check("t5_count15", out_count, 15);
      end
    end
    check("t5_valid16", out_valid, 1);
    check("t5_acc16", out_acc, 16);
    check("t5_count16", out_count, 16);
    step();
    send_term(4'd1, 4'd1, 1'b0); step(); step();
    check("t5_valid17", out_valid, 0);
    check("t5_count17", out_count, 1);
    check("t5_acc17", out_acc, 1);

    // T6 asynchronous reset in S_MUL
    send_term(4'd2, 4'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_acc", out_acc, 0);
    check("t6_rst_count", out_count, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    #1;
    rst_n = 1'b1;
    step();

    // T6 clear in S_ACC discards the term
    send_term(4'd3, 4'd3, 1'b1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t6_clr_acc", out_acc, 0);
    check("t6_clr_count", out_count, 0);
    check("t6_clr_valid", out_valid, 0);
    check("t6_clr_ready", in_ready, 1);
    step();
    check("t6_clr_valid2", out_valid, 0);

    // clr suppresses acceptance
    in_a = 4'd5; in_b = 4'd5; in_last = 1'b1;
    in_valid = 1'b1; clr = 1'b1;
    step();
    in_valid = 1'b0; clr = 1'b0;
    check("clr_block_ready", in_ready, 1);
    step(); step();
    check("clr_block_valid", out_valid, 0);
    check("clr_block_acc", out_acc, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
